// File: rtl/vga_sync_receiver.sv
// VGA timing receiver: recovers active-area coordinates from hsync/vsync/blank_b,
// checks line/frame geometry and reports lock, frame starts and sync errors.
module vga_sync_receiver #(
  parameter int H_ACTIVE    = 640,
  parameter int H_TOTAL     = 800,
  parameter int V_ACTIVE    = 480,
  parameter int V_TOTAL     = 525,
  parameter int LOCK_FRAMES = 2
) (
  input  logic       vgaclk,
  input  logic       rst_n,
  input  logic       hsync,
  input  logic       vsync,
  input  logic       blank_b,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       pixel_valid,
  output logic       frame_start,
  output logic       locked,
  output logic       sync_err
);

  localparam logic [9:0]  CNT_MAX = 10'h3FF;
  localparam logic [9:0]  X_LAST  = 10'(H_ACTIVE - 1);
  localparam logic [9:0]  Y_LAST  = 10'(V_ACTIVE - 1);
  localparam logic [10:0] H_TOT   = 11'(H_TOTAL);
  localparam logic [10:0] V_TOT   = 11'(V_TOTAL);
  localparam logic [10:0] H_ACT   = 11'(H_ACTIVE);
  localparam logic [2:0]  LOCK_N  = 3'(LOCK_FRAMES);

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_e;

  state_e     state_q;
  logic       hsync_s_q, vsync_s_q, blank_s_q;
  logic       hsync_p_q, vsync_p_q, blank_p_q;
  logic       seen_q;
  logic [2:0] good_q;
  logic [9:0] h_cnt_q, h_cnt_d;
  logic [9:0] v_cnt_q, v_cnt_d;
  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic       pixel_valid_q, frame_start_q, locked_q, sync_err_q;

  logic h_fall, v_fall, b_rise, b_fall;
  logic x_ovf, line_err, frame_err, active_err, tmo, err;

  assign h_fall = hsync_p_q & ~hsync_s_q;
  assign v_fall = vsync_p_q & ~vsync_s_q;
  assign b_rise = blank_s_q & ~blank_p_q;
  assign b_fall = ~blank_s_q & blank_p_q;

  always_comb begin
    h_cnt_d = (h_cnt_q == CNT_MAX) ? h_cnt_q : h_cnt_q + 10'd1;
    if (h_fall) h_cnt_d = '0;

    v_cnt_d = v_cnt_q;
    if (v_fall) v_cnt_d = '0;
    else if (h_fall && v_cnt_q != CNT_MAX) v_cnt_d = v_cnt_q + 10'd1;

    x_d   = x_q;
    x_ovf = 1'b0;
    if (b_rise) x_d = '0;
    else if (blank_s_q) begin
      if (x_q == X_LAST) x_ovf = 1'b1;
      else x_d = x_q + 10'd1;
    end

    y_d = y_q;
    if (v_fall) y_d = '0;
    else if (b_fall && y_q != Y_LAST) y_d = y_q + 10'd1;

    // An hsync fall coinciding with the vsync fall still belongs to the ending frame.
    line_err   = h_fall && (({1'b0, h_cnt_q} + 11'd1) != H_TOT);
    frame_err  = v_fall && (({1'b0, v_cnt_q} + {10'd0, h_fall}) != V_TOT);
    active_err = b_fall && (({1'b0, x_q} + 11'd1) != H_ACT);
    tmo        = (h_cnt_d == CNT_MAX) || (v_cnt_d == CNT_MAX);
    err        = (state_q != SEARCH) &&
                 (line_err || frame_err || active_err || tmo || x_ovf);
  end

  always_ff @(posedge vgaclk or negedge rst_n) begin
    if (!rst_n) begin
      hsync_s_q <= 1'b1;
      vsync_s_q <= 1'b1;
      blank_s_q <= 1'b0;
      hsync_p_q <= 1'b1;
      vsync_p_q <= 1'b1;
      blank_p_q <= 1'b0;
      seen_q    <= 1'b0;
      h_cnt_q   <= '0;
      v_cnt_q   <= '0;
      x_q       <= '0;
      y_q       <= '0;
    end else begin
      hsync_s_q <= hsync;
      vsync_s_q <= vsync;
      blank_s_q <= blank_b;
      hsync_p_q <= hsync_s_q;
      vsync_p_q <= vsync_s_q;
      blank_p_q <= blank_s_q;
      seen_q    <= seen_q | h_fall;
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
      x_q       <= x_d;
      y_q       <= y_d;
    end
  end

  // Errors take priority over any lock progress made by a simultaneous vsync fall.
  always_ff @(posedge vgaclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= SEARCH;
      good_q        <= '0;
      locked_q      <= 1'b0;
      pixel_valid_q <= 1'b0;
      frame_start_q <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      sync_err_q    <= 1'b0;
      frame_start_q <= 1'b0;
      pixel_valid_q <= blank_s_q & locked_q;
      if (err) begin
        state_q       <= SEARCH;
        good_q        <= '0;
        locked_q      <= 1'b0;
        pixel_valid_q <= 1'b0;
        sync_err_q    <= 1'b1;
      end else begin
        case (state_q)
          SEARCH: begin
            good_q <= '0;
            if (v_fall && (seen_q || h_fall)) state_q <= MEASURE;
          end
          MEASURE: begin
            if (v_fall) begin
              good_q <= good_q + 3'd1;
              if (good_q + 3'd1 == LOCK_N) begin
                state_q       <= LOCKED;
                locked_q      <= 1'b1;
                pixel_valid_q <= blank_s_q;
              end
            end
          end
          LOCKED: begin
            if (v_fall) frame_start_q <= 1'b1;
          end
          default: state_q <= SEARCH;
        endcase
      end
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign pixel_valid = pixel_valid_q;
  assign frame_start = frame_start_q;
  assign locked      = locked_q;
  assign sync_err    = sync_err_q;

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Directed bench for vga_sync_receiver on a reduced 16x6 (24x10 total) geometry;
// expectations are queued at drive time and compared two cycles later.
module tb_vga_sync_receiver;

  localparam int HA = 16;
  localparam int HT = 24;
  localparam int VA = 6;
  localparam int VT = 10;
  localparam int LF = 2;

  logic       vgaclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       hsync = 1'b1;
  logic       vsync = 1'b1;
  logic       blank_b = 1'b0;
  logic [9:0] x, y;
  logic       pixel_valid, frame_start, locked, sync_err;

  vga_sync_receiver #(
    .H_ACTIVE(HA), .H_TOTAL(HT), .V_ACTIVE(VA), .V_TOTAL(VT), .LOCK_FRAMES(LF)
  ) dut (
    .vgaclk(vgaclk), .rst_n(rst_n), .hsync(hsync), .vsync(vsync), .blank_b(blank_b),
    .x(x), .y(y), .pixel_valid(pixel_valid), .frame_start(frame_start),
    .locked(locked), .sync_err(sync_err)
  );

  always #5 vgaclk = ~vgaclk;

  typedef struct packed {
    int         cyc;
    logic [9:0] xe;
    logic [9:0] ye;
    logic       chkY;
    logic       pv;
    logic       fs;
    logic       lk;
    logic       err;
  } exp_t;

  exp_t       sb[$];
  int         cyc = 0;
  int         passCnt = 0;
  int         checkCnt = 0;
  int         failCnt = 0;
  logic       prevH = 1'b1, prevV = 1'b1;
  logic       hSeen = 1'b0, lockE = 1'b0, errNext = 1'b0;
  int         goodV = 0;
  logic [9:0] lastX = '0;

  task automatic checkOutput(input string tag, input logic [9:0] obs, input logic [9:0] expv);
    checkCnt++;
    assert (obs === expv) passCnt++;
    else begin
      failCnt++;
      $error("[TB] FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, expv);
    end
  endtask

  task automatic resetModel();
    sb.delete();
    prevH = 1'b1; prevV = 1'b1;
    hSeen = 1'b0; lockE = 1'b0; errNext = 1'b0;
    goodV = 0; lastX = '0;
  endtask

  task automatic checkAllZero(input string pfx);
    checkOutput({pfx, "_x"}, x, 10'd0);
    checkOutput({pfx, "_y"}, y, 10'd0);
    checkOutput({pfx, "_pixel_valid"}, {9'd0, pixel_valid}, 10'd0);
    checkOutput({pfx, "_frame_start"}, {9'd0, frame_start}, 10'd0);
    checkOutput({pfx, "_locked"}, {9'd0, locked}, 10'd0);
    checkOutput({pfx, "_sync_err"}, {9'd0, sync_err}, 10'd0);
  endtask

  // One pixel clock: compare the entry queued two cycles ago, then drive and queue.
  // Lock is expected once LF+1 vsync falls have followed an hsync fall with no error.
  task automatic applyStimulus(input logic h, input logic v, input logic b,
                               input logic errHere, input int col, input int row);
    exp_t e, o;
    logic hf, vf, err;
    @(negedge vgaclk);
    cyc++;
    if (sb.size() > 0 && sb[0].cyc + 2 == cyc) begin
      o = sb.pop_front();
      checkOutput("x", x, o.xe);
      if (o.chkY) checkOutput("y", y, o.ye);
      checkOutput("pixel_valid", {9'd0, pixel_valid}, {9'd0, o.pv});
      checkOutput("frame_start", {9'd0, frame_start}, {9'd0, o.fs});
      checkOutput("locked", {9'd0, locked}, {9'd0, o.lk});
      checkOutput("sync_err", {9'd0, sync_err}, {9'd0, o.err});
    end
    hsync = h; vsync = v; blank_b = b;
    hf = prevH & ~h;
    vf = prevV & ~v;
    err = errHere | errNext;
    errNext = 1'b0;
    hSeen = hSeen | hf;
    e.fs = 1'b0;
    if (err) begin
      goodV = 0;
      lockE = 1'b0;
    end else if (vf && hSeen) begin
      e.fs = lockE;
      goodV++;
      lockE = (goodV > LF);
    end
    if (b) lastX = 10'((col > HA - 1) ? HA - 1 : col);
    e.cyc = cyc; e.xe = lastX; e.ye = 10'(row); e.chkY = b;
    e.pv = b & lockE; e.lk = lockE; e.err = err;
    sb.push_back(e);
    prevH = h; prevV = v;
  endtask

  // Line L: hsync low 0..3, active 6..21 on lines 3..8, vsync low on lines 0..1.
  task automatic sendLine(input int L, input int extraFront, input int extraActive, input int nCyc);
    int   total;
    logic act;
    total = HT + extraFront;
    for (int p = 0; p < total && p < nCyc; p++) begin
      act = (L >= 3 && L < 3 + VA) && (p >= 6) && (p < 6 + HA + extraActive);
      applyStimulus(p >= 4, L >= 2, act, (extraActive > 0) && (p == 6 + HA), p - 6, L - 3);
    end
    if (extraFront > 0) errNext = 1'b1;
  endtask

  task automatic sendFrame(input int longLine, input int ovfLine, input bit shortF);
    for (int L = 0; L < VT; L++) begin
      if (shortF && L == VT - 1) continue;
      sendLine(L, (L == longLine) ? 1 : 0, (L == ovfLine) ? 1 : 0, HT + 2);
    end
    if (shortF) errNext = 1'b1;
  endtask

  initial begin
    repeat (3) @(negedge vgaclk);
    checkAllZero("reset");
    rst_n = 1'b1;
    resetModel();

    // Clean stream: partial frame, then five full frames.
    repeat (4) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 0, 0);
    sendLine(VT - 1, 0, 0, HT + 2);
    repeat (5) sendFrame(-1, -1, 1'b0);

    // One 25-clock line while locked, then relock.
    sendFrame(5, -1, 1'b0);
    repeat (3) sendFrame(-1, -1, 1'b0);

    // blank_b high one pixel too long.
    sendFrame(-1, 4, 1'b0);
    repeat (3) sendFrame(-1, -1, 1'b0);

    // Frame one line short: the following vsync fall carries the error.
    sendFrame(-1, -1, 1'b1);
    repeat (4) sendFrame(-1, -1, 1'b0);

    // hsync stuck high until h_cnt reaches 1023.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
    repeat (1022) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 0, 0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 0, 0);
    repeat (3) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 0, 0);

    @(negedge vgaclk);
    rst_n = 1'b0;
    resetModel();
    @(negedge vgaclk);
    checkAllZero("reset2");
    rst_n = 1'b1;

    // vsync pulses with no hsync must not start measurement.
    repeat (2) begin
      repeat (3) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 0, 0);
      repeat (2) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
      repeat (5) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 0, 0);
    end
    sendLine(VT - 1, 0, 0, HT + 2);
    repeat (4) sendFrame(-1, -1, 1'b0);
    sendLine(0, 0, 0, 10);

    #1 rst_n = 1'b0;
    #1;
    checkAllZero("async_reset");
    resetModel();

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
